// File: rtl/alu_issue_seq_pkg.sv
// alu_issue_seq_pkg: constants and types shared by the ALU issue sequencer and its unit decoder.
//   WIDTH        default operand/result width of the execution units
//   UNIT_*       2-bit execution-unit select codes (req_fun[3:2])
//   state_e      sequencer FSM state encoding
//   cmp_fun_e    compare-unit sub-function codes (req_fun[1:0] when UNIT_CMP)
package alu_issue_seq_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMP_NOP = 2'b00,
        CMP_EQ  = 2'b01,
        CMP_GT  = 2'b10,
        CMP_LT  = 2'b11
    } cmp_fun_e;

endpackage

// File: rtl/alu_unit_decode.sv
// alu_unit_decode: combinational map of a 2-bit unit select plus a valid bit to a one-hot unit enable.
// Ports:
//   sel_i    unit select (UNIT_ARITH/LOGIC/CMP/SHIFT)
//   valid_i  when low, no enable is produced
//   en_o     one-hot enable, bit index equals the unit select code
module alu_unit_decode
    import alu_issue_seq_pkg::*;
(
    input  logic [1:0] sel_i,
    input  logic       valid_i,
    output logic [3:0] en_o
);

    always_comb begin
        en_o = 4'b0000;
        en_o[UNIT_ARITH] = valid_i && (sel_i == UNIT_ARITH);
        en_o[UNIT_LOGIC] = valid_i && (sel_i == UNIT_LOGIC);
        en_o[UNIT_CMP]   = valid_i && (sel_i == UNIT_CMP);
        en_o[UNIT_SHIFT] = valid_i && (sel_i == UNIT_SHIFT);
    end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: upstream sequencer that issues one operation at a time to the ALU execution units
// and returns the selected unit's registered result on a valid/ready handshake.
// Ports:
//   CLK, RST                       clock, synchronous active-low reset
//   req_valid/req_ready            request handshake; req_a, req_b operands, req_fun [3:2] unit, [1:0] sub-function
//   A, B, ALU_FUN                  operands and sub-function driven to the units (held until next accept)
//   *_Enable                       one-hot unit enables, high for exactly the ISSUE cycle
//   *_OUT, *_Flag                  registered unit results and flags
//   res_valid/res_ready            result handshake; res_data, res_flag, res_unit captured result
//   op_count                       completed-result counter
// Optional feature: define ALU_ISSUE_OPCOUNT_EN to enable a saturating op_count; otherwise op_count is 0.
module alu_issue_seq
    import alu_issue_seq_pkg::*;
#(
    parameter int Width = WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [Width-1:0] req_a,
    input  logic [Width-1:0] req_b,
    input  logic [3:0]       req_fun,
    output logic [Width-1:0] A,
    output logic [Width-1:0] B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic [Width-1:0] Arith_OUT,
    input  logic [Width-1:0] Logic_OUT,
    input  logic [Width-1:0] CMP_OUT,
    input  logic [Width-1:0] Shift_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Width-1:0] res_data,
    output logic             res_flag,
    output logic [1:0]       res_unit,
    output logic [15:0]      op_count
);

    state_e           state_q;
    logic             req_ready_q;
    logic [Width-1:0] a_q;
    logic [Width-1:0] b_q;
    logic [1:0]       fun_q;
    logic [1:0]       unit_q;
    logic [3:0]       en_q;
    logic             res_valid_q;
    logic [Width-1:0] res_data_q;
    logic             res_flag_q;
    logic [1:0]       res_unit_q;

    logic             accept;
    logic             done;
    logic [3:0]       en_d;
    logic [Width-1:0] cap_data_d;
    logic             cap_flag_d;

    // req_ready_q is only ever high in IDLE, so it alone qualifies the accept
    assign accept = req_ready_q && req_valid;
    assign done   = res_valid_q && res_ready;

    // Enables are decoded at the accept edge so they are registered and high
    // for exactly the ISSUE cycle; they fall again at the ISSUE->CAPTURE edge.
    alu_unit_decode u_decode (
        .sel_i   (req_fun[3:2]),
        .valid_i (accept),
        .en_o    (en_d)
    );

    always_comb begin
        cap_data_d = (unit_q == UNIT_ARITH) ? Arith_OUT :
                     (unit_q == UNIT_LOGIC) ? Logic_OUT :
                     (unit_q == UNIT_CMP)   ? CMP_OUT   : Shift_OUT;
        cap_flag_d = (unit_q == UNIT_ARITH) ? Arith_Flag :
                     (unit_q == UNIT_LOGIC) ? Logic_Flag :
                     (unit_q == UNIT_CMP)   ? CMP_Flag   : Shift_Flag;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= 2'b00;
            unit_q      <= 2'b00;
            en_q        <= 4'b0000;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            res_unit_q  <= 2'b00;
        end else begin
            en_q <= en_d;
            case (state_q)
                IDLE: begin
                    // ready rises one cycle after reset release, then drops on accept
                    req_ready_q <= !accept;
                    if (accept) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        fun_q   <= req_fun[1:0];
                        unit_q  <= req_fun[3:2];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= CAPTURE;
                CAPTURE: begin
                    // unit results were registered at the ISSUE->CAPTURE edge
                    res_data_q  <= cap_data_d;
                    res_flag_q  <= cap_flag_d;
                    res_unit_q  <= unit_q;
                    res_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign Arith_Enable = en_q[UNIT_ARITH];
    assign Logic_Enable = en_q[UNIT_LOGIC];
    assign CMP_Enable   = en_q[UNIT_CMP];
    assign Shift_Enable = en_q[UNIT_SHIFT];
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_flag     = res_flag_q;
    assign res_unit     = res_unit_q;

`ifdef ALU_ISSUE_OPCOUNT_EN
    logic [15:0] op_count_q;
    logic [15:0] op_count_d;

    assign op_count_d = (done && (op_count_q != 16'hFFFF)) ? op_count_q + 16'd1 : op_count_q;

    always_ff @(posedge CLK) begin
        if (!RST) op_count_q <= 16'h0000;
        else      op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`else
    logic unused_done;
    assign unused_done = done;
    assign op_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: randomized and directed bench for alu_issue_seq with execution-unit models and a timeline reference model.
module tb_alu_issue_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0, req_b = '0;
    logic [3:0]  req_fun = '0;
    logic [15:0] A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
    logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_flag;
    logic [1:0]  res_unit;
    logic [15:0] op_count;
    logic [3:0]  en;

    int n_checks = 0;
    int n_errs = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_t [4];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

    alu_issue_seq #(.Width(16)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flag(res_flag), .res_unit(res_unit),
        .op_count(op_count)
    );

    // Behaviour of each execution unit: returns {flag, result}.
    function automatic logic [16:0] unit_fn(input logic [1:0] u, input logic [1:0] f,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        fl;
        r  = '0;
        fl = 1'b0;
        case (u)
            2'b00: begin
                case (f)
                    2'd0: {fl, r} = {1'b0, a} + {1'b0, b};
                    2'd1: begin r = a - b; fl = a < b; end
                    2'd2: r = a * b;
                    default: r = a + 16'd1;
                endcase
            end
            2'b01: begin
                case (f)
                    2'd0: r = a & b;
                    2'd1: r = a | b;
                    2'd2: r = a ^ b;
                    default: r = ~(a & b);
                endcase
                fl = (r == 16'h0000);
            end
            2'b10: begin
                case (f)
                    2'd0: r = 16'h0000;
                    2'd1: r = {15'b0, a == b};
                    2'd2: r = {15'b0, a > b};
                    default: r = {15'b0, a < b};
                endcase
                fl = r[0];
            end
            default: begin
                case (f)
                    2'd0: r = a << b[3:0];
                    2'd1: r = a >> b[3:0];
                    2'd2: r = {a[14:0], a[15]};
                    default: r = {a[0], a[15:1]};
                endcase
                fl = r[15];
            end
        endcase
        return {fl, r};
    endfunction

    // Unit models: registered results when enabled; arith/logic/shift emit noise
    // when idle, the compare unit zeroes its output when idle.
    always @(posedge CLK) begin
        {Arith_Flag, Arith_OUT} <= Arith_Enable ? unit_fn(2'b00, ALU_FUN, A, B) : 17'($urandom);
        {Logic_Flag, Logic_OUT} <= Logic_Enable ? unit_fn(2'b01, ALU_FUN, A, B) : 17'($urandom);
        {CMP_Flag, CMP_OUT}     <= CMP_Enable   ? unit_fn(2'b10, ALU_FUN, A, B) : 17'd0;
        {Shift_Flag, Shift_OUT} <= Shift_Enable ? unit_fn(2'b11, ALU_FUN, A, B) : 17'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model as an operation timeline: age counts cycles since the accept edge.
    bit          m_inflight = 0;
    int          m_age = 0;
    bit          m_rdy = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [1:0]  m_fun = '0, m_unit = '0;
    logic [16:0] m_exp = '0;
    logic [15:0] m_hold_data = '0;
    logic        m_hold_flag = 1'b0;
    logic [1:0]  m_hold_unit = '0;
    logic [15:0] m_cnt = '0;

    always @(negedge CLK) begin
        chk("req_ready", req_ready, m_rdy);
        chk("A", A, m_a);
        chk("B", B, m_b);
        chk("ALU_FUN", ALU_FUN, m_fun);
        chk("enables", en, (m_inflight && m_age == 1) ? (4'b0001 << m_unit) : 4'b0000);
        chk("res_valid", res_valid, m_inflight && m_age >= 3);
        chk("res_data", res_data, m_hold_data);
        chk("res_flag", res_flag, m_hold_flag);
        chk("res_unit", res_unit, m_hold_unit);
        chk("op_count", op_count, m_cnt);
        if (!RST) begin
            m_inflight = 0; m_age = 0; m_rdy = 0;
            m_a = '0; m_b = '0; m_fun = '0; m_unit = '0;
            m_hold_data = '0; m_hold_flag = 1'b0; m_hold_unit = '0; m_cnt = '0;
        end else if (m_inflight) begin
            if (m_age >= 3 && res_ready) begin
                m_inflight = 0;
                m_rdy = 1;
`ifdef ALU_ISSUE_OPCOUNT_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end else begin
                m_age++;
                if (m_age == 3) begin
                    m_hold_data = m_exp[15:0];
                    m_hold_flag = m_exp[16];
                    m_hold_unit = m_unit;
                end
            end
        end else if (m_rdy && req_valid) begin
            m_inflight = 1; m_age = 1; m_rdy = 0;
            m_a = req_a; m_b = req_b; m_fun = req_fun[1:0]; m_unit = req_fun[3:2];
            m_exp = unit_fn(req_fun[3:2], req_fun[1:0], req_a, req_b);
        end else begin
            m_rdy = 1;
        end
    end

    task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input bit keep);
        bit got = 0;
        @(posedge CLK); #1;
        req_fun = f; req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = req_ready;
        end
        if (!got) begin
            n_checks++; n_errs++;
            $display("FAIL send_timeout: req_ready stayed 0 expected 1");
        end
        @(posedge CLK); #1;
        last_acc = cyc;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            got = req_ready;
        end
        if (!got) begin
            n_checks++; n_errs++;
            $display("FAIL idle_timeout: req_ready stayed 0 expected 1");
        end
    endtask

    initial begin
        // reset held for two cycles with a pending request
        req_valid = 1'b1; req_fun = 4'b0000; req_a = 16'h1234; req_b = 16'h0101;
        repeat (2) begin
            @(negedge CLK);
            chk("rst_req_ready", req_ready, 1'b0);
            chk("rst_res_valid", res_valid, 1'b0);
            chk("rst_op_count", op_count, 16'h0000);
        end
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK); chk("post_rst_ready0", req_ready, 1'b0);
        @(negedge CLK); chk("post_rst_ready1", req_ready, 1'b1);
        @(posedge CLK); #1 req_valid = 1'b0;
        @(negedge CLK); chk("first_accept_A", A, 16'h1234);
        chk("first_accept_arith_en", en, 4'b0001);
        res_ready = 1'b1;
        wait_idle();

        // compare equal with 5 cycles of backpressure
        @(posedge CLK); #1 res_ready = 1'b0;
        send(4'b1001, 16'h0005, 16'h0005, 0);
        @(negedge CLK); chk("cmp_en_issue", en, 4'b0100);
        @(negedge CLK); chk("cmp_en_capture", en, 4'b0000);
        chk("cmp_valid_capture", res_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_res_valid", res_valid, 1'b1);
            chk("bp_res_data", res_data, 16'h0001);
            chk("bp_res_flag", res_flag, 1'b1);
            chk("bp_res_unit", res_unit, 2'b10);
            chk("bp_req_ready", req_ready, 1'b0);
        end
        @(posedge CLK); #1 res_ready = 1'b1;
        @(posedge CLK); #1 res_ready = 1'b0;
        @(negedge CLK);
        chk("bp_done_valid", res_valid, 1'b0);
        chk("bp_done_ready", req_ready, 1'b1);

        // back-to-back, one request per unit, req_valid held
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send({i[1:0], 2'($urandom)}, 16'($urandom), 16'($urandom), 1);
            acc_t[i] = last_acc;
            @(negedge CLK); chk("b2b_unit_en", en, 4'b0001 << i);
        end
        @(posedge CLK); #1 req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_t[i] - acc_t[i-1], 4);
        wait_idle();

        // reset during CAPTURE discards the operation
        send(4'b0110, 16'h00F0, 16'h0F00, 0);
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        chk("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_en", en, 4'b0000);
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_res_data", res_data, 16'h0000);
        repeat (3) begin
            @(negedge CLK); chk("midrst_no_result", res_valid, 1'b0);
        end

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #1;
            req_valid = $urandom_range(0, 9) < 6;
            req_fun   = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = ($urandom_range(0, 3) == 0) ? req_a : 16'($urandom);
            res_ready = $urandom_range(0, 2) != 0;
            RST       = $urandom_range(0, 99) != 0;
        end
        @(posedge CLK); #1 RST = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
        wait_idle();

        // completed-op counter
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1 RST = 1'b1;
        for (int i = 0; i < 3; i++) send(4'($urandom), 16'($urandom), 16'($urandom), 0);
        wait_idle();
`ifdef ALU_ISSUE_OPCOUNT_EN
        chk("op_count_3", op_count, 16'h0003);
        @(posedge CLK); #1;
        force dut.op_count_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        @(negedge CLK); #1 release dut.op_count_q;
        for (int i = 0; i < 2; i++) send(4'($urandom), 16'($urandom), 16'($urandom), 0);
        wait_idle();
        chk("op_count_sat", op_count, 16'hFFFF);
        send(4'b0000, 16'h0001, 16'h0001, 0);
        wait_idle();
        chk("op_count_hold", op_count, 16'hFFFF);
`else
        chk("op_count_off", op_count, 16'h0000);
`endif
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
